// File: rtl/ysyx_22040386_pkg.sv
// rtl/ysyx_22040386_pkg.sv - shared IF stage types and constants
package ysyx_22040386_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_e;

  localparam logic [31:0] RV_NOP            = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC  = 64'h8000_0000;
  localparam logic [63:0] DEFAULT_INST_STEP = 64'd4;

  function automatic logic [63:0] align_target(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22040386_ifu.sv
// rtl/ysyx_22040386_ifu.sv - instruction fetch unit with single outstanding imem request
module ysyx_22040386_ifu
  import ysyx_22040386_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [63:0] INST_STEP = DEFAULT_INST_STEP
) (
  input  logic        i_IF_clk,
  input  logic        i_IF_rst,
  input  logic        i_IF_redirect,
  input  logic [63:0] i_IF_redirect_pc,
  output logic        o_IF_imem_req,
  output logic [63:0] o_IF_imem_addr,
  input  logic        i_IF_imem_gnt,
  input  logic        i_IF_imem_rvalid,
  input  logic [31:0] i_IF_imem_rdata,
  output logic        o_IF_valid,
  input  logic        i_IF_id_ready,
  output logic [63:0] o_IF_pc,
  output logic [31:0] o_IF_inst,
  output logic [63:0] o_IF_fetch_cnt
);

  if_state_e   state_q;
  logic [63:0] pc_q;
  logic [63:0] cnt_q;
  logic [31:0] inst_q;
  logic        drop_q;
  logic [63:0] target_d;

  assign target_d = align_target(i_IF_redirect_pc);

  always_ff @(posedge i_IF_clk) begin
    if (i_IF_rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      cnt_q   <= 64'd0;
      inst_q  <= RV_NOP;
      drop_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (i_IF_redirect) pc_q <= target_d;
          if (i_IF_imem_gnt) begin
            state_q <= S_WAIT;
            drop_q  <= i_IF_redirect;
          end
        end
        S_WAIT: begin
          if (i_IF_redirect) pc_q <= target_d;
          // A response arriving with the redirect is itself the stale one, so nothing is left to drop.
          if (i_IF_imem_rvalid) begin
            drop_q <= 1'b0;
            if (drop_q || i_IF_redirect) begin
              state_q <= S_REQ;
            end else begin
              inst_q  <= i_IF_imem_rdata;
              state_q <= S_HOLD;
            end
          end else if (i_IF_redirect) begin
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (i_IF_redirect) begin
            pc_q    <= target_d;
            state_q <= S_REQ;
          end else if (i_IF_id_ready) begin
            pc_q    <= pc_q + INST_STEP;
            cnt_q   <= cnt_q + 64'd1;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign o_IF_imem_req  = !i_IF_rst && (state_q == S_REQ);
  assign o_IF_imem_addr = pc_q;
  assign o_IF_valid     = !i_IF_rst && (state_q == S_HOLD) && !i_IF_redirect;
  assign o_IF_pc        = pc_q;
  assign o_IF_inst      = inst_q;
  assign o_IF_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_22040386_ifu.sv
// tb/tb_ysyx_22040386_ifu.sv - self-checking bench for the instruction fetch unit
module tb_ysyx_22040386_ifu;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, redir, gnt, rvalid, ready;
  logic [63:0] redir_pc;
  logic [31:0] rdata;
  logic        imem_req, valid;
  logic [63:0] imem_addr, out_pc, fetch_cnt;
  logic [31:0] out_inst;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ysyx_22040386_ifu dut (
    .i_IF_clk         (clk),
    .i_IF_rst         (rst),
    .i_IF_redirect    (redir),
    .i_IF_redirect_pc (redir_pc),
    .o_IF_imem_req    (imem_req),
    .o_IF_imem_addr   (imem_addr),
    .i_IF_imem_gnt    (gnt),
    .i_IF_imem_rvalid (rvalid),
    .i_IF_imem_rdata  (rdata),
    .o_IF_valid       (valid),
    .i_IF_id_ready    (ready),
    .o_IF_pc          (out_pc),
    .o_IF_inst        (out_inst),
    .o_IF_fetch_cnt   (fetch_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: next fetch address, whether a granted fetch is
  // outstanding (and already superseded), and whether an instruction is being offered.
  logic [63:0] m_pc      = RST_PC;
  logic [63:0] m_cnt     = 64'd0;
  logic [31:0] m_inst    = 32'h0000_0013;
  bit          m_waiting = 1'b0;
  bit          m_stale   = 1'b0;
  bit          m_have    = 1'b0;
  bit          e_req, e_valid;
  logic [63:0] tgt;

  always @(negedge clk) begin
    e_req   = !rst && !m_waiting && !m_have;
    e_valid = !rst && m_have && !redir;
    chk("model_req", {63'd0, imem_req}, {63'd0, e_req});
    if (e_req) chk("model_addr", imem_addr, m_pc);
    chk("model_valid", {63'd0, valid}, {63'd0, e_valid});
    if (e_valid) begin
      chk("model_pc", out_pc, m_pc);
      chk("model_inst", {32'd0, out_inst}, {32'd0, m_inst});
    end
    chk("model_cnt", fetch_cnt, m_cnt);

    tgt = redir_pc & ~64'd3;
    if (rst) begin
      m_pc = RST_PC; m_cnt = 64'd0; m_waiting = 0; m_stale = 0; m_have = 0;
    end else if (m_have) begin
      if (redir) begin
        m_pc = tgt; m_have = 0;
      end else if (ready) begin
        m_pc = m_pc + 64'd4; m_cnt = m_cnt + 64'd1; m_have = 0;
      end
    end else if (m_waiting) begin
      if (rvalid) begin
        m_waiting = 0;
        if (!m_stale && !redir) begin
          m_have = 1; m_inst = rdata;
        end
        m_stale = 0;
      end else if (redir) begin
        m_stale = 1;
      end
      if (redir) m_pc = tgt;
    end else begin
      if (gnt) begin
        m_waiting = 1; m_stale = redir;
      end
      if (redir) m_pc = tgt;
    end
  end

  task automatic drive(input bit rs, input bit g, input bit rv, input logic [31:0] rd,
                       input bit rdy, input bit rdr, input logic [63:0] rpc);
    @(posedge clk);
    #1;
    rst = rs; gnt = g; rvalid = rv; rdata = rd; ready = rdy; redir = rdr; redir_pc = rpc;
    #1;
  endtask

  function automatic logic [31:0] memfn(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9e37_79b9;
  endfunction

  int          mem_cnt;
  logic [63:0] mem_addr;

  initial begin
    rst = 1; gnt = 0; rvalid = 0; rdata = 0; ready = 0; redir = 0; redir_pc = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_cnt", fetch_cnt, 64'd0);

    // basic fetch, then decode stall for five cycles
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("t1_req", {63'd0, imem_req}, 64'd1);
    chk("t1_addr", imem_addr, 64'h8000_0000);
    drive(0, 0, 1, 32'h0010_0093, 0, 0, 0);
    chk("t1_wait_req", {63'd0, imem_req}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("t2_valid", {63'd0, valid}, 64'd1);
      chk("t2_pc", out_pc, 64'h8000_0000);
      chk("t2_inst", {32'd0, out_inst}, 64'h0010_0093);
      chk("t2_noreq", {63'd0, imem_req}, 64'd0);
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("t2_accept", {63'd0, valid}, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t1_next_addr", imem_addr, 64'h8000_0004);
    chk("t1_cnt", fetch_cnt, 64'd1);

    // redirect while waiting: stale response must be dropped
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 64'h8000_0102);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'hDEAD_BEEF, 1, 0, 0);
    chk("t3_novalid", {63'd0, valid}, 64'd0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("t3_addr", imem_addr, 64'h8000_0100);
    chk("t3_req", {63'd0, imem_req}, 64'd1);

    // redirect beats ready in hold
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h1234_5678, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 64'h8000_0300);
    chk("t4_valid", {63'd0, valid}, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t4_addr", imem_addr, 64'h8000_0300);
    chk("t4_cnt", fetch_cnt, 64'd1);

    // no grant for ten cycles, redirect on the fourth
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, i == 3, 64'h8000_0200);
      chk("t5_req", {63'd0, imem_req}, 64'd1);
      chk("t5_addr", imem_addr, (i <= 3) ? 64'h8000_0300 : 64'h8000_0200);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("t5_gnt_addr", imem_addr, 64'h8000_0200);

    // reset while waiting; late response is ignored
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("t6_rst_req", {63'd0, imem_req}, 64'd0);
    drive(0, 0, 1, 32'hCAFE_F00D, 1, 0, 0);
    chk("t6_addr", imem_addr, 64'h8000_0000);
    chk("t6_valid", {63'd0, valid}, 64'd0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("t6_req", {63'd0, imem_req}, 64'd1);
    chk("t6_cnt", fetch_cnt, 64'd0);

    mem_cnt = 0;
    mem_addr = 0;
    for (int c = 0; c < 4000; c++) begin
      bit rs, g, rv, rdy, rdr, busy;
      logic [31:0] rd;
      logic [63:0] rpc;
      busy = (mem_cnt != 0);
      if (busy) mem_cnt--;
      rv = busy && (mem_cnt == 0);
      rd = rv ? memfn(mem_addr) : $urandom;
      if (!busy && !m_waiting && $urandom_range(0, 15) == 0) rv = 1;
      g   = (!busy && !rv) ? ($urandom_range(0, 2) != 0) : 1'b0;
      rs  = ($urandom_range(0, 299) == 0);
      rdy = $urandom_range(0, 1);
      rdr = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = {$urandom, $urandom};
        1:       rpc = 64'hFFFF_FFFF_FFFF_FFFC | 64'($urandom_range(0, 3));
        default: rpc = RST_PC + 64'($urandom_range(0, 4095));
      endcase
      drive(rs, g, rv, rd, rdy, rdr, rpc);
      if (imem_req && g) begin
        mem_addr = imem_addr;
        mem_cnt  = $urandom_range(1, 3);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
